exec_stage_mc: RTL and testbench
================================

Name: exec_stage_mc

Overview:
Parametrised execute stage for the pipelined core. Sits between the decode/execute and memory pipeline registers. Single-cycle ALU ops, branch/jump resolution, and an E/M pipeline register are carried forward from the current execute stage. New: generic data/register widths, a valid bit through the pipe, and an iterative multi-cycle multiply/divide unit that stalls upstream with a busy handshake.

Parameters:
DATA_W, 16, datapath, PC and immediate width
REG_ADDR_W, 4, destination register index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
validE  in  1  E-stage holds a real instruction
regWriteE  in  1  register-file write enable
memWriteE  in  1  data-memory write enable
jumpE  in  1  unconditional jump
branchE  in  1  conditional branch, taken on ALU zero
aluSrcE  in  1  0: B=RD2E, 1: B=extendedE
resultSrcE  in  2  writeback source select, passed through
aluControlE  in  4  ALU operation
RD1E  in  DATA_W  operand A
RD2E  in  DATA_W  operand B / store data
PCPlus2E  in  DATA_W  PC+2, passed through
PCE  in  DATA_W  PC of instruction
extendedE  in  DATA_W  sign-extended immediate
RdE  in  REG_ADDR_W  destination register
busyE  out  1  stall request to fetch/decode, combinational
PCSrcE  out  1  redirect PC, combinational
PCTargetE  out  DATA_W  PCE+extendedE, combinational
validM, regWriteM, memWriteM  out  1 each  registered
resultSrcM  out  2  registered
PCPlus2M, aluResM, writeDataM  out  DATA_W each  registered
RdM  out  REG_ADDR_W  registered

Behaviour:
- Reset (rst=0, async): FSM -> IDLE; all registered outputs 0; busyE=0. Reset mid-operation abandons the op with no partial result.
- ALU codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT signed (result 1/0), 0110 SLL by B[3:0], 0111 SRL by B[3:0], 1000 MUL (low DATA_W bits), 1001 DIVU quotient, 1010 REMU. All others give 0. Add/sub wrap modulo 2^DATA_W.
- zero = (single-cycle ALU result == 0). PCSrcE = validE & (jumpE | (branchE & zero)). PCTargetE = PCE+extendedE, wrapping.
- Single-cycle op: E/M register loads every edge while busyE=0. writeDataM=RD2E; other controls pass through. validM=validE. regWriteM and memWriteM are forced to 0 when validE=0.
- Multi-cycle FSM states IDLE, MUL, DIV, DONE:
  - IDLE: if validE and op in {1000,1001,1010}: busyE=1; latch A/B/op; counter=0; go to MUL (1000) or DIV.
  - MUL: shift-add, one bit per cycle; busyE=1; after DATA_W cycles go to DONE.
  - DIV: unsigned restoring, one bit per cycle; busyE=1; after DATA_W cycles go to DONE.
  - DONE: busyE=0; aluResM loads the FSM result with the held E controls; go to IDLE.
- While busyE=1, the E/M register loads a bubble: validM=0, regWriteM=0, memWriteM=0, other fields 0.
- Upstream holds all E inputs stable while busyE=1.
- Latency: busyE is high for DATA_W+1 cycles (17 at default); the result appears on M at the edge ending the DONE cycle.
- Divide by zero: quotient is all ones; remainder is the dividend. No trap.
- Multi-cycle ops never assert PCSrcE. A branch/jump in the E stage resolves in the same cycle.

Optional Feature:
EXEC_MULDIV_EN:
- Defined: the MUL/DIVU/REMU FSM is built as above.
- Undefined: the FSM and datapath are omitted. Codes 1000-1010 give 0 in one cycle, busyE is tied 0, and the M stage sees normal single-cycle timing.

Test Plan:
- rst=0 with random E inputs -> all M outputs 0, busyE=0; release, validE=0 -> validM=0, regWriteM=0.
- ADD RD1E=0x0003, aluSrcE=1, extendedE=0x0005, RdE=4, regWriteE=1 -> next edge aluResM=0x0008, RdM=4, regWriteM=1, validM=1.
- SUB with RD1E=RD2E=0x1234, branchE=1, PCE=0x0010, extendedE=0x0008 -> PCSrcE=1, PCTargetE=0x0018. With RD2E=0x1235 -> PCSrcE=0. jumpE=1 with any operands -> PCSrcE=1.
- MUL 0x0007*0x0006 -> busyE high 17 cycles with bubbles on M (validM=0), then aluResM=0x002A, validM=1. MUL 0xFFFF*0x0002 -> 0xFFFE.
- DIVU 0x0064/0x0007 -> 0x000E; REMU -> 0x0002; DIVU 0x0064/0 -> 0xFFFF; REMU 0x0064/0 -> 0x0064.
- rst=0 at iteration 5 of MUL -> busyE=0 and M cleared immediately. After release, ADD 1+1 -> aluResM=0x0002 in one cycle.

Source files
------------

// File: rtl/exec_stage_mc_if.sv
// Execute-stage bus: decoded E-stage inputs, branch resolution, busy handshake and M-stage outputs.
// master = upstream/downstream pipeline side, slave = the execute stage itself.
interface exec_stage_mc_if #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
);
    logic                  validE;
    logic                  regWriteE;
    logic                  memWriteE;
    logic                  jumpE;
    logic                  branchE;
    logic                  aluSrcE;
    logic [1:0]            resultSrcE;
    logic [3:0]            aluControlE;
    logic [DATA_W-1:0]     RD1E;
    logic [DATA_W-1:0]     RD2E;
    logic [DATA_W-1:0]     PCPlus2E;
    logic [DATA_W-1:0]     PCE;
    logic [DATA_W-1:0]     extendedE;
    logic [REG_ADDR_W-1:0] RdE;

    logic                  busyE;
    logic                  PCSrcE;
    logic [DATA_W-1:0]     PCTargetE;

    logic                  validM;
    logic                  regWriteM;
    logic                  memWriteM;
    logic [1:0]            resultSrcM;
    logic [DATA_W-1:0]     PCPlus2M;
    logic [DATA_W-1:0]     aluResM;
    logic [DATA_W-1:0]     writeDataM;
    logic [REG_ADDR_W-1:0] RdM;

    modport master (
        output validE, regWriteE, memWriteE, jumpE, branchE, aluSrcE, resultSrcE,
               aluControlE, RD1E, RD2E, PCPlus2E, PCE, extendedE, RdE,
        input  busyE, PCSrcE, PCTargetE, validM, regWriteM, memWriteM, resultSrcM,
               PCPlus2M, aluResM, writeDataM, RdM
    );

    modport slave (
        input  validE, regWriteE, memWriteE, jumpE, branchE, aluSrcE, resultSrcE,
               aluControlE, RD1E, RD2E, PCPlus2E, PCE, extendedE, RdE,
        output busyE, PCSrcE, PCTargetE, validM, regWriteM, memWriteM, resultSrcM,
               PCPlus2M, aluResM, writeDataM, RdM
    );
endinterface

// File: rtl/exec_stage_mc.sv
// Execute stage: single-cycle ALU, branch/jump resolution and E/M pipeline register.
// Define EXEC_MULDIV_EN to build the iterative MUL/DIVU/REMU unit that stalls upstream via busyE.
module exec_stage_mc #(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    exec_stage_mc_if.slave bus
);
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic              zero;
    logic              busy;
    logic              mc_done;
    logic [DATA_W-1:0] mc_result;
    logic              branch_block;

    assign alu_b = bus.aluSrcE ? bus.extendedE : bus.RD2E;

    always_comb begin
        alu_res = '0;
        case (bus.aluControlE)
            4'b0000: alu_res = bus.RD1E + alu_b;
            4'b0001: alu_res = bus.RD1E - alu_b;
            4'b0010: alu_res = bus.RD1E & alu_b;
            4'b0011: alu_res = bus.RD1E | alu_b;
            4'b0100: alu_res = bus.RD1E ^ alu_b;
            4'b0101: alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.RD1E) < $signed(alu_b))};
            4'b0110: alu_res = bus.RD1E << alu_b[3:0];
            4'b0111: alu_res = bus.RD1E >> alu_b[3:0];
            default: alu_res = '0;
        endcase
    end

    assign zero          = (alu_res == '0);
    assign bus.PCTargetE = bus.PCE + bus.extendedE;
    assign bus.PCSrcE    = bus.validE & ~branch_block & (bus.jumpE | (bus.branchE & zero));
    assign bus.busyE     = rst & busy;

`ifdef EXEC_MULDIV_EN
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W:0]     acc_q, acc_d;
    logic                quot_sel_q, quot_sel_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W:0]     rem_shift;
    logic [DATA_W:0]     rem_diff;
    logic                is_md_op;
    logic                last_step;

    assign is_md_op     = (bus.aluControlE == 4'b1000) | (bus.aluControlE == 4'b1001) |
                          (bus.aluControlE == 4'b1010);
    assign branch_block = is_md_op;
    assign last_step    = (cnt_q == CNT_W'(DATA_W - 1));

    // Restoring divide: a_q shifts the dividend out and the quotient in, acc_q is the partial remainder.
    assign rem_shift = {acc_q[DATA_W-1:0], a_q[DATA_W-1]};
    assign rem_diff  = rem_shift - {1'b0, b_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            quot_sel_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            quot_sel_q <= quot_sel_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        quot_sel_d = quot_sel_q;
        cnt_d      = cnt_q;
        busy       = 1'b0;
        mc_done    = 1'b0;
        mc_result  = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.validE && is_md_op) begin
                    busy       = 1'b1;
                    a_d        = bus.RD1E;
                    b_d        = alu_b;
                    acc_d      = '0;
                    cnt_d      = '0;
                    quot_sel_d = (bus.aluControlE == 4'b1001);
                    state_d    = (bus.aluControlE == 4'b1000) ? S_MUL : S_DIV;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (b_q[0]) begin
                    acc_d = {1'b0, acc_q[DATA_W-1:0] + a_q};
                end
                a_d     = a_q << 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                state_d = last_step ? S_DONE : S_MUL;
            end
            S_DIV: begin
                busy = 1'b1;
                if (!rem_diff[DATA_W]) begin
                    acc_d = rem_diff;
                    a_d   = {a_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift;
                    a_d   = {a_q[DATA_W-2:0], 1'b0};
                end
                cnt_d   = cnt_q + 1'b1;
                state_d = last_step ? S_DONE : S_DIV;
            end
            S_DONE: begin
                mc_done   = 1'b1;
                mc_result = quot_sel_q ? a_q : acc_q[DATA_W-1:0];
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end
`else
    assign busy         = 1'b0;
    assign mc_done      = 1'b0;
    assign mc_result    = '0;
    assign branch_block = 1'b0;
`endif

    logic                  valid_q, valid_d;
    logic                  reg_write_q, reg_write_d;
    logic                  mem_write_q, mem_write_d;
    logic [1:0]            result_src_q, result_src_d;
    logic [DATA_W-1:0]     pc_plus2_q, pc_plus2_d;
    logic [DATA_W-1:0]     alu_res_q, alu_res_d;
    logic [DATA_W-1:0]     write_data_q, write_data_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;

    // A stalled stage pushes a bubble; otherwise the held or fresh instruction advances.
    always_comb begin
        valid_d      = 1'b0;
        reg_write_d  = 1'b0;
        mem_write_d  = 1'b0;
        result_src_d = '0;
        pc_plus2_d   = '0;
        alu_res_d    = '0;
        write_data_d = '0;
        rd_d         = '0;
        if (!busy) begin
            valid_d      = bus.validE;
            reg_write_d  = bus.regWriteE & bus.validE;
            mem_write_d  = bus.memWriteE & bus.validE;
            result_src_d = bus.resultSrcE;
            pc_plus2_d   = bus.PCPlus2E;
            alu_res_d    = mc_done ? mc_result : alu_res;
            write_data_d = bus.RD2E;
            rd_d         = bus.RdE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_write_q  <= 1'b0;
            result_src_q <= '0;
            pc_plus2_q   <= '0;
            alu_res_q    <= '0;
            write_data_q <= '0;
            rd_q         <= '0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_write_q  <= mem_write_d;
            result_src_q <= result_src_d;
            pc_plus2_q   <= pc_plus2_d;
            alu_res_q    <= alu_res_d;
            write_data_q <= write_data_d;
            rd_q         <= rd_d;
        end
    end

    assign bus.validM     = valid_q;
    assign bus.regWriteM  = reg_write_q;
    assign bus.memWriteM  = mem_write_q;
    assign bus.resultSrcM = result_src_q;
    assign bus.PCPlus2M   = pc_plus2_q;
    assign bus.aluResM    = alu_res_q;
    assign bus.writeDataM = write_data_q;
    assign bus.RdM        = rd_q;
endmodule

// File: tb/tb_exec_stage_mc.sv
// Self-checking bench for exec_stage_mc: directed literal cases plus randomized traffic against
// a cycle-count reference model. Honours EXEC_MULDIV_EN the same way the design does.
module tb_exec_stage_mc;
    localparam int W = 16;
`ifdef EXEC_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    exec_stage_mc_if #(.DATA_W(W), .REG_ADDR_W(4)) bus ();
    exec_stage_mc #(.DATA_W(W), .REG_ADDR_W(4)) dut (.clk(clk), .rst(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic bit is_md(input logic [3:0] op);
        return (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
    endfunction

    // Architectural result of an operation; muldiv codes only produce a value when md is set.
    function automatic logic [W-1:0] ref_result(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input bit md);
        int unsigned ua, ub, prod;
        ua   = int'(a);
        ub   = int'(b);
        prod = ua * ub;
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            4'd6:  return a << b[3:0];
            4'd7:  return a >> b[3:0];
            4'd8:  return md ? prod[W-1:0] : '0;
            4'd9:  return !md ? '0 : (ub == 0) ? '1 : W'(ua / ub);
            4'd10: return !md ? '0 : (ub == 0) ? a : W'(ua % ub);
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] opb();
        return bus.aluSrcE ? bus.extendedE : bus.RD2E;
    endfunction

    // Model: mc_cnt counts cycles since a muldiv op was accepted; W+1 marks the result cycle.
    int               mc_cnt = 0;
    logic             e_valid = 0, e_rw = 0, e_mw = 0;
    logic [1:0]       e_rs = '0;
    logic [W-1:0]     e_pc2 = '0, e_res = '0, e_wd = '0;
    logic [3:0]       e_rd = '0;

    function automatic bit model_busy();
        if (!MD || !rst_n) return 1'b0;
        if (mc_cnt == 0) return bus.validE && is_md(bus.aluControlE);
        return mc_cnt <= W;
    endfunction

    function automatic bit model_pcsrc();
        logic [W-1:0] r;
        r = ref_result(bus.aluControlE, bus.RD1E, opb(), 1'b0);
        if (MD && is_md(bus.aluControlE)) return 1'b0;
        return bus.validE && (bus.jumpE || (bus.branchE && (r == '0)));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_cnt <= 0;
            e_valid <= 0; e_rw <= 0; e_mw <= 0; e_rs <= '0;
            e_pc2 <= '0; e_res <= '0; e_wd <= '0; e_rd <= '0;
        end else if (model_busy()) begin
            mc_cnt <= mc_cnt + 1;
            e_valid <= 0; e_rw <= 0; e_mw <= 0; e_rs <= '0;
            e_pc2 <= '0; e_res <= '0; e_wd <= '0; e_rd <= '0;
        end else begin
            mc_cnt  <= 0;
            e_valid <= bus.validE;
            e_rw    <= bus.regWriteE & bus.validE;
            e_mw    <= bus.memWriteE & bus.validE;
            e_rs    <= bus.resultSrcE;
            e_pc2   <= bus.PCPlus2E;
            e_wd    <= bus.RD2E;
            e_rd    <= bus.RdE;
            e_res   <= ref_result(bus.aluControlE, bus.RD1E, opb(), mc_cnt == W + 1);
        end
    end

    always @(negedge clk) begin
        chk("busyE", 32'(bus.busyE), 32'(model_busy()));
        chk("PCSrcE", 32'(bus.PCSrcE), 32'(model_pcsrc()));
        chk("PCTargetE", 32'(bus.PCTargetE), 32'(W'(bus.PCE + bus.extendedE)));
        chk("validM", 32'(bus.validM), 32'(e_valid));
        chk("regWriteM", 32'(bus.regWriteM), 32'(e_rw));
        chk("memWriteM", 32'(bus.memWriteM), 32'(e_mw));
        chk("resultSrcM", 32'(bus.resultSrcM), 32'(e_rs));
        chk("PCPlus2M", 32'(bus.PCPlus2M), 32'(e_pc2));
        chk("aluResM", 32'(bus.aluResM), 32'(e_res));
        chk("writeDataM", 32'(bus.writeDataM), 32'(e_wd));
        chk("RdM", 32'(bus.RdM), 32'(e_rd));
    end

    task automatic drive_random();
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        bus.validE      = ($urandom_range(0, 3) != 0);
        bus.regWriteE   = 1'($urandom);
        bus.memWriteE   = 1'($urandom);
        bus.aluSrcE     = 1'($urandom);
        bus.resultSrcE  = 2'($urandom);
        bus.aluControlE = op;
        bus.RD1E        = 16'($urandom);
        bus.RD2E        = ($urandom_range(0, 3) == 0) ? bus.RD1E : 16'($urandom);
        bus.extendedE   = ($urandom_range(0, 3) == 0) ? bus.RD1E : 16'($urandom);
        if ($urandom_range(0, 5) == 0) begin
            bus.RD2E      = '0;
            bus.extendedE = '0;
        end
        bus.PCPlus2E    = 16'($urandom);
        bus.PCE         = 16'($urandom);
        bus.RdE         = 4'($urandom);
        bus.branchE     = is_md(op) ? 1'b0 : ($urandom_range(0, 3) == 0);
        bus.jumpE       = is_md(op) ? 1'b0 : ($urandom_range(0, 7) == 0);
    endtask

    // Issue one op at posedge+1, wait for it to leave E, then check M against a literal.
    task automatic run_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit use_imm, input logic [W-1:0] exp,
                          input logic [3:0] rd);
        int  lat;
        bit  done;
        bus.validE = 1; bus.regWriteE = 1; bus.memWriteE = 0; bus.jumpE = 0; bus.branchE = 0;
        bus.resultSrcE = 2'b01; bus.aluControlE = op; bus.RD1E = a;
        bus.aluSrcE = use_imm;
        bus.RD2E = use_imm ? 16'h5A5A : b;
        bus.extendedE = use_imm ? b : 16'h0000;
        bus.PCPlus2E = 16'h0102; bus.PCE = 16'h0100; bus.RdE = rd;
        lat = 0;
        done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.busyE) begin
                done = 1;
                break;
            end
            lat++;
        end
        chk({name, " completes"}, 32'(done), 32'(1));
        chk({name, " busy cycles"}, 32'(lat), (MD && is_md(op)) ? 32'(W + 1) : 32'(0));
        @(posedge clk);
        #1;
        chk({name, " aluResM"}, 32'(bus.aluResM), 32'(exp));
        chk({name, " validM"}, 32'(bus.validM), 32'(1));
        chk({name, " RdM"}, 32'(bus.RdM), 32'(rd));
        $display("txn %s op=%0d a=0x%04h b=0x%04h -> aluResM=0x%04h busy=%0d", name, op, a, b,
                 bus.aluResM, lat);
        bus.validE = 0;
    endtask

    initial begin
        drive_random();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            drive_random();
            bus.validE = 1;
            bus.aluControlE = 4'd8;
            bus.branchE = 0;
            bus.jumpE = 0;
            #1;
            chk("reset busyE", 32'(bus.busyE), 32'(0));
            chk("reset validM", 32'(bus.validM), 32'(0));
            chk("reset aluResM", 32'(bus.aluResM), 32'(0));
        end
        @(posedge clk);
        #1;
        bus.validE = 0;
        bus.regWriteE = 1;
        rst_n = 1;
        @(posedge clk);
        #1;
        chk("idle validM", 32'(bus.validM), 32'(0));
        chk("idle regWriteM", 32'(bus.regWriteM), 32'(0));
        $display("txn reset release validM=%0d regWriteM=%0d", bus.validM, bus.regWriteM);

        run_op("ADD imm", 4'd0, 16'h0003, 16'h0005, 1'b1, 16'h0008, 4'd4);

        bus.validE = 1; bus.aluControlE = 4'd1; bus.aluSrcE = 0; bus.branchE = 1; bus.jumpE = 0;
        bus.RD1E = 16'h1234; bus.RD2E = 16'h1234; bus.PCE = 16'h0010; bus.extendedE = 16'h0008;
        #1;
        chk("BEQ taken PCSrcE", 32'(bus.PCSrcE), 32'(1));
        chk("BEQ PCTargetE", 32'(bus.PCTargetE), 32'h0018);
        bus.RD2E = 16'h1235;
        #1;
        chk("BEQ not taken PCSrcE", 32'(bus.PCSrcE), 32'(0));
        bus.branchE = 0; bus.jumpE = 1;
        #1;
        chk("JUMP PCSrcE", 32'(bus.PCSrcE), 32'(1));
        $display("txn branch/jump PCTargetE=0x%04h", bus.PCTargetE);
        bus.jumpE = 0;
        bus.validE = 0;
        @(posedge clk);
        #1;

        run_op("MUL 7*6", 4'd8, 16'h0007, 16'h0006, 1'b0, MD ? 16'h002A : 16'h0000, 4'd1);
        run_op("MUL FFFF*2", 4'd8, 16'hFFFF, 16'h0002, 1'b0, MD ? 16'hFFFE : 16'h0000, 4'd2);
        run_op("DIVU 100/7", 4'd9, 16'h0064, 16'h0007, 1'b0, MD ? 16'h000E : 16'h0000, 4'd3);
        run_op("REMU 100%7", 4'd10, 16'h0064, 16'h0007, 1'b0, MD ? 16'h0002 : 16'h0000, 4'd5);
        run_op("DIVU by 0", 4'd9, 16'h0064, 16'h0000, 1'b0, MD ? 16'hFFFF : 16'h0000, 4'd6);
        run_op("REMU by 0", 4'd10, 16'h0064, 16'h0000, 1'b0, MD ? 16'h0064 : 16'h0000, 4'd7);

        // Abort a multiply part-way through with reset.
        bus.validE = 1; bus.regWriteE = 1; bus.aluControlE = 4'd8; bus.aluSrcE = 0;
        bus.RD1E = 16'h0007; bus.RD2E = 16'h0006; bus.branchE = 0; bus.jumpE = 0;
        repeat (6) @(posedge clk);
        #1;
        rst_n = 0;
        #1;
        chk("abort busyE", 32'(bus.busyE), 32'(0));
        chk("abort validM", 32'(bus.validM), 32'(0));
        chk("abort aluResM", 32'(bus.aluResM), 32'(0));
        $display("txn reset during MUL busyE=%0d validM=%0d", bus.busyE, bus.validM);
        bus.validE = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
        run_op("ADD after abort", 4'd0, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'd8);

        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            if (mc_cnt == 0) drive_random();
        end
        bus.validE = 0;
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
